// File: rtl/mem_arbiter_ctrl.sv
// mem_arbiter_ctrl: shares one byte-wide RAM port between the fetch unit
// (word reads) and the load/store buffer (byte/half/word reads and writes).
// Multi-byte accesses are split into little-endian byte beats. Each access
// returns a 32-bit result with a one-cycle done pulse.
//   clk, rst, rdy, clear      : clock, sync reset, global ready, flush
//   if_req/if_addr            : fetch request;  if_done/if_data  : result
//   lsb_req/wr/addr/size/wdata: load/store;     lsb_done/rdata   : result
//   mem_din/mem_dout/mem_a/mem_wr : RAM pins (registered read data)
module mem_arbiter_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int IF_BYTES   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  clear,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_done,
  output logic [31:0]           if_data,
  input  logic                  lsb_req,
  input  logic                  lsb_wr,
  input  logic [ADDR_WIDTH-1:0] lsb_addr,
  input  logic [1:0]            lsb_size,
  input  logic [31:0]           lsb_wdata,
  output logic                  lsb_done,
  output logic [31:0]           lsb_rdata,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  typedef enum logic {OWN_IF, OWN_LSB} owner_t;

  localparam logic [2:0] IF_LEN = 3'(IF_BYTES);

  state_t                state_q, state_d;
  owner_t                owner_q, owner_d;
  owner_t                last_grant_q, last_grant_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [2:0]            len_q, len_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           buf_q, buf_d;
  logic [31:0]           if_data_q, if_data_d;
  logic [31:0]           lsb_rdata_q, lsb_rdata_d;
  logic [7:0]            mem_dout_q, mem_dout_d;
  logic                  mem_wr_q, mem_wr_d;
  logic                  if_done_q, if_done_d;
  logic                  lsb_done_q, lsb_done_d;

  logic [2:0]            cnt_inc;
  logic [1:0]            cnt_lo;
  logic [31:0]           din_shift;
  logic [31:0]           rd_word;
  logic [2:0]            size_len;
  logic [7:0]            next_byte;
  logic                  pick_if;
  logic                  pick_lsb;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    addr_d       = addr_q;
    mem_a_d      = mem_a_q;
    wdata_d      = wdata_q;
    buf_d        = buf_q;
    if_data_d    = if_data_q;
    lsb_rdata_d  = lsb_rdata_q;
    mem_dout_d   = mem_dout_q;
    mem_wr_d     = mem_wr_q;
    if_done_d    = 1'b0;
    lsb_done_d   = 1'b0;
    pick_if      = 1'b0;
    pick_lsb     = 1'b0;

    cnt_inc   = cnt_q + 3'd1;
    // Read data lags the address by two edges: the byte arriving now is beat cnt-1.
    cnt_lo    = cnt_q[1:0] - 2'd1;
    din_shift = {24'd0, mem_din} << {cnt_lo, 3'b000};
    rd_word   = buf_q | din_shift;

    case (lsb_size)
      2'b00:   size_len = 3'd1;
      2'b01:   size_len = 3'd2;
      default: size_len = 3'd4;
    endcase

    case (cnt_inc[1:0])
      2'd1:    next_byte = wdata_q[15:8];
      2'd2:    next_byte = wdata_q[23:16];
      2'd3:    next_byte = wdata_q[31:24];
      default: next_byte = wdata_q[7:0];
    endcase

    // With rdy low everything holds except the done flags, which stay one-cycle pulses.
    if (rdy) begin
      case (state_q)
        IDLE: begin
          if (!clear && !if_done_q && !lsb_done_q) begin
            pick_if  = if_req && (!lsb_req || last_grant_q == OWN_LSB);
            pick_lsb = lsb_req && !pick_if;
            if (pick_if) begin
              owner_d      = OWN_IF;
              last_grant_d = OWN_IF;
              addr_d       = if_addr;
              len_d        = IF_LEN;
              mem_a_d      = if_addr;
              mem_wr_d     = 1'b0;
              cnt_d        = '0;
              buf_d        = '0;
              state_d      = READ;
            end else if (pick_lsb) begin
              owner_d      = OWN_LSB;
              last_grant_d = OWN_LSB;
              addr_d       = lsb_addr;
              len_d        = size_len;
              wdata_d      = lsb_wdata;
              mem_a_d      = lsb_addr;
              mem_wr_d     = lsb_wr;
              cnt_d        = '0;
              buf_d        = '0;
              if (lsb_wr) begin
                mem_dout_d = lsb_wdata[7:0];
                state_d    = WRITE;
              end else begin
                state_d    = READ;
              end
            end
          end
        end

        READ: begin
          if (clear) begin
            state_d = IDLE;
            mem_a_d = '0;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc < len_q) begin
              mem_a_d = addr_q + ADDR_WIDTH'(cnt_inc);
            end
            if (cnt_q != 3'd0) begin
              buf_d = rd_word;
            end
            if (cnt_q == len_q) begin
              state_d = IDLE;
              if (owner_q == OWN_IF) begin
                if_done_d = 1'b1;
                if_data_d = rd_word;
              end else begin
                lsb_done_d  = 1'b1;
                lsb_rdata_d = rd_word;
              end
            end
          end
        end

        WRITE: begin
          cnt_d = cnt_inc;
          if (cnt_inc < len_q) begin
            mem_a_d    = addr_q + ADDR_WIDTH'(cnt_inc);
            mem_dout_d = next_byte;
          end else begin
            mem_wr_d   = 1'b0;
            lsb_done_d = 1'b1;
            state_d    = IDLE;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_IF;
      last_grant_q <= OWN_LSB;
      cnt_q        <= '0;
      len_q        <= '0;
      addr_q       <= '0;
      mem_a_q      <= '0;
      wdata_q      <= '0;
      buf_q        <= '0;
      if_data_q    <= '0;
      lsb_rdata_q  <= '0;
      mem_dout_q   <= '0;
      mem_wr_q     <= 1'b0;
      if_done_q    <= 1'b0;
      lsb_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      addr_q       <= addr_d;
      mem_a_q      <= mem_a_d;
      wdata_q      <= wdata_d;
      buf_q        <= buf_d;
      if_data_q    <= if_data_d;
      lsb_rdata_q  <= lsb_rdata_d;
      mem_dout_q   <= mem_dout_d;
      mem_wr_q     <= mem_wr_d;
      if_done_q    <= if_done_d;
      lsb_done_q   <= lsb_done_d;
    end
  end

  assign if_done   = if_done_q;
  assign if_data   = if_data_q;
  assign lsb_done  = lsb_done_q;
  assign lsb_rdata = lsb_rdata_q;
  assign mem_dout  = mem_dout_q;
  assign mem_a     = mem_a_q;
  assign mem_wr    = mem_wr_q;

endmodule
